// File: rtl/markov_next_token.sv
// Weighted next-token picker for the Markov learner's transition list.
// First pass totals matching counts; second pass walks cumulative counts against an LFSR threshold.
module markov_next_token #(
    parameter int          TOKEN_W   = 8,
    parameter int          COUNT_W   = 8,
    parameter int          ADDR_W    = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [TOKEN_W-1:0]  cur_token,
    input  logic [ADDR_W:0]     list_len,
    output logic [ADDR_W-1:0]   tbl_addr,
    input  logic [TOKEN_W-1:0]  tbl_from,
    input  logic [TOKEN_W-1:0]  tbl_to,
    input  logic [COUNT_W-1:0]  tbl_count,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [TOKEN_W-1:0]  next_token
);

    localparam int SUM_W  = COUNT_W + ADDR_W;
    localparam int PROD_W = 16 + SUM_W;
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SUM    = 3'd1,
        S_DRAW   = 3'd2,
        S_SELECT = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Right-shifting Galois LFSR, taps 0xB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        if (cur[0]) begin
            lfsr_step = (cur >> 1) ^ 16'hB400;
        end else begin
            lfsr_step = cur >> 1;
        end
    endfunction

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [TOKEN_W-1:0]   tok_q, tok_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [SUM_W-1:0]     total_q, total_d;
    logic [SUM_W-1:0]     acc_q, acc_d;
    logic [SUM_W-1:0]     thr_q, thr_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 found_q, found_d;
    logic [TOKEN_W-1:0]   next_q, next_d;

    logic                 match_s;
    logic [SUM_W-1:0]     count_ext_s;
    logic [SUM_W-1:0]     acc_sum_s;
    logic [PROD_W-1:0]    prod_s;

    assign match_s     = rd_vld_q && (tbl_from == tok_q);
    assign count_ext_s = {{ADDR_W{1'b0}}, tbl_count};
    assign acc_sum_s   = acc_q + count_ext_s;
    assign prod_s      = PROD_W'(lfsr_q) * PROD_W'(total_q);

    // Next-state and datapath updates for the two-pass scan.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        tok_d    = tok_q;
        rd_vld_d = 1'b0;
        total_d  = total_q;
        acc_d    = acc_q;
        thr_d    = thr_q;
        lfsr_d   = lfsr_q;
        done_d   = 1'b0;
        found_d  = found_q;
        next_d   = next_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SUM;
                    cnt_d   = {LEN_W{1'b0}};
                    tok_d   = cur_token;
                    total_d = {SUM_W{1'b0}};
                    acc_d   = {SUM_W{1'b0}};
                    if (list_len > MAX_LEN) begin
                        len_d = MAX_LEN;
                    end else begin
                        len_d = list_len;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SUM: begin
                // rd_vld tracks whether the address on tbl_addr this cycle is a real entry.
                rd_vld_d = (cnt_q < len_q);
                if (match_s) begin
                    total_d = total_q + count_ext_s;
                end else begin
                    total_d = total_q;
                end
                if (cnt_q == len_q) begin
                    state_d  = S_DRAW;
                    cnt_d    = {LEN_W{1'b0}};
                    rd_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_DRAW: begin
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = {LEN_W{1'b0}};
                acc_d  = {SUM_W{1'b0}};
                if (total_q == {SUM_W{1'b0}}) begin
                    state_d = S_FINISH;
                    found_d = 1'b0;
                    next_d  = tok_q;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_SELECT;
                    thr_d   = prod_s[PROD_W-1:16];
                end
            end
            S_SELECT: begin
                rd_vld_d = (cnt_q < len_q);
                if (match_s) begin
                    acc_d = acc_sum_s;
                end else begin
                    acc_d = acc_q;
                end
                if (match_s && (acc_sum_s > thr_q)) begin
                    state_d = S_FINISH;
                    found_d = 1'b1;
                    next_d  = tbl_to;
                    done_d  = 1'b1;
                end else if (cnt_q == len_q) begin
                    // Unreachable with a stable list; fail safe to "no pick".
                    state_d = S_FINISH;
                    found_d = 1'b0;
                    next_d  = tok_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {LEN_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            tok_q    <= {TOKEN_W{1'b0}};
            rd_vld_q <= 1'b0;
            total_q  <= {SUM_W{1'b0}};
            acc_q    <= {SUM_W{1'b0}};
            thr_q    <= {SUM_W{1'b0}};
            lfsr_q   <= LFSR_SEED;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            next_q   <= {TOKEN_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            tok_q    <= tok_d;
            rd_vld_q <= rd_vld_d;
            total_q  <= total_d;
            acc_q    <= acc_d;
            thr_q    <= thr_d;
            lfsr_q   <= lfsr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            next_q   <= next_d;
        end
    end

    assign tbl_addr   = cnt_q[ADDR_W-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign next_token = next_q;

endmodule

// File: tb/tb_markov_next_token.sv
// Directed bench for markov_next_token: a small list memory with one-cycle read latency,
// hand-computed LFSR thresholds and done-cycle expectations.
module tb_markov_next_token;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] cur_token;
    logic [6:0] list_len;
    logic [5:0] tbl_addr;
    logic [7:0] tbl_from;
    logic [7:0] tbl_to;
    logic [7:0] tbl_count;
    logic       busy;
    logic       done;
    logic       found;
    logic [7:0] next_token;

    logic [7:0] mem_from [64];
    logic [7:0] mem_to   [64];
    logic [7:0] mem_cnt  [64];

    int checks;
    int failures;

    markov_next_token #(
        .TOKEN_W  (8),
        .COUNT_W  (8),
        .ADDR_W   (6),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cur_token (cur_token),
        .list_len  (list_len),
        .tbl_addr  (tbl_addr),
        .tbl_from  (tbl_from),
        .tbl_to    (tbl_to),
        .tbl_count (tbl_count),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .next_token(next_token)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // List memory: data valid one cycle after the address.
    always @(posedge clk) begin
        tbl_from  <= mem_from[tbl_addr];
        tbl_to    <= mem_to[tbl_addr];
        tbl_count <= mem_cnt[tbl_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int idx, input logic [7:0] f, input logic [7:0] t, input logic [7:0] c);
        mem_from[idx] = f;
        mem_to[idx]   = t;
        mem_cnt[idx]  = c;
    endtask

    task automatic load_weighted();
        set_entry(0, 8'd3, 8'd10, 8'd1);
        set_entry(1, 8'd4, 8'd99, 8'd50);
        set_entry(2, 8'd3, 8'd11, 8'd1);
        set_entry(3, 8'd3, 8'd12, 8'd2);
    endtask

    // One request: cycle 1 is the first negedge after the accepting posedge.
    task automatic run_req(input string tag, input logic [7:0] tok, input logic [6:0] len,
                           input int exp_cyc, input logic exp_found, input logic [7:0] exp_next,
                           input bit poke_busy);
        int cyc;
        int extra_done;
        @(negedge clk);
        start     = 1'b1;
        cur_token = tok;
        list_len  = len;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check_eq({tag, "_busy1"}, 32'(busy), 32'd1);
        while (!done && cyc < 300) begin
            if (poke_busy && cyc == 2) begin
                start     = 1'b1;
                cur_token = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_found"}, 32'(found), 32'(exp_found));
        check_eq({tag, "_next"}, 32'(next_token), 32'(exp_next));
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check_eq({tag, "_extra_done"}, 32'(extra_done), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_held_next"}, 32'(next_token), 32'(exp_next));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        cur_token = 8'd0;
        list_len  = 7'd0;
        for (int i = 0; i < 64; i++) set_entry(i, 8'hFF, 8'hFF, 8'd0);

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_found", 32'(found), 32'd0);
        check_eq("rst_next", 32'(next_token), 32'd0);
        check_eq("rst_addr", 32'(tbl_addr), 32'd0);
        reset = 1'b0;

        // LFSR 0xACE1, total 4 -> threshold 2 -> pick index 3.
        load_weighted();
        run_req("weighted", 8'd3, 7'd4, 12, 1'b1, 8'd12, 1'b0);

        // LFSR 0xE270, total 3 -> threshold 2, acc 3 picks.
        set_entry(0, 8'd5, 8'd9, 8'd3);
        run_req("single", 8'd5, 7'd1, 6, 1'b1, 8'd9, 1'b0);

        set_entry(0, 8'd1, 8'd2, 8'd4);
        run_req("nomatch", 8'd7, 7'd1, 4, 1'b0, 8'd7, 1'b0);

        run_req("empty", 8'h21, 7'd0, 3, 1'b0, 8'h21, 1'b0);

        // Four DRAWs later LFSR is 0x1C4E -> threshold 0 -> index 0.
        load_weighted();
        run_req("weighted_adv", 8'd3, 7'd4, 9, 1'b1, 8'd10, 1'b0);

        // Reset in SUM; LFSR would be 0x0E27 (pick 10) unless reseeded.
        @(negedge clk);
        start     = 1'b1;
        cur_token = 8'd3;
        list_len  = 7'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_found", 32'(found), 32'd0);
        check_eq("midrst_next", 32'(next_token), 32'd0);
        reset = 1'b0;
        run_req("rerun", 8'd3, 7'd4, 12, 1'b1, 8'd12, 1'b0);

        // LFSR 0xE270, total 5 -> threshold 4; zero-count entry skipped.
        set_entry(0, 8'd2, 8'd8, 8'd0);
        set_entry(1, 8'd2, 8'd6, 8'd5);
        run_req("zerocnt", 8'd2, 7'd2, 8, 1'b1, 8'd6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
